// File: rtl/serial_write_buffer.sv
// Parallel-to-serial transmit buffer: loads a right-aligned word on start and
// shifts it out MSB-first, one bit per write_sig strobe.
module serial_write_buffer #(
    parameter int   BUF_SIZE = 8,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         write_sig,
    input  logic [BUF_SIZE-1:0]          data_in,
    input  logic [$clog2(BUF_SIZE+1)-1:0] write_count,
    output logic                         data_out,
    output logic                         done_sig
);

    localparam int CW = $clog2(BUF_SIZE+1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [BUF_SIZE-1:0] sh_q, sh_d;
    logic [CW-1:0]       rem_q, rem_d;
    logic                data_out_q;
    logic                done_q;

    logic [CW-1:0]       eff_n;
    logic [BUF_SIZE-1:0] load_word;

    // Oversized counts are clamped; the load left-justifies the word so the
    // first bit to send always sits at the MSB of the shift register.
    assign eff_n     = (write_count > CW'(BUF_SIZE)) ? CW'(BUF_SIZE) : write_count;
    assign load_word = data_in << (CW'(BUF_SIZE) - eff_n);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start && (eff_n != '0)) begin
                    state_d = SHIFT;
                    sh_d    = load_word;
                    rem_d   = eff_n;
                end
            end
            SHIFT: begin
                if (write_sig) begin
                    sh_d  = sh_q << 1;
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they change on the
    // same edge as the state they describe.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            rem_q      <= '0;
            data_out_q <= IDLE_VAL;
            done_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            rem_q      <= rem_d;
            data_out_q <= (state_d == SHIFT) ? sh_d[BUF_SIZE-1] : IDLE_VAL;
            done_q     <= (state_d == IDLE);
        end
    end

    assign data_out = data_out_q;
    assign done_sig = done_q;

endmodule
